// File: rtl/button_debounce.sv
// Push-button front end: synchronises a raw asynchronous input and rejects contact bounce,
// producing a clean registered level plus one-cycle rise/fall strobes.
module button_debounce #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // One-hot so that corrupted encodings are detectable and forced back to LOW.
    localparam logic [3:0] StLow      = 4'b0001;
    localparam logic [3:0] StWaitHigh = 4'b0010;
    localparam logic [3:0] StHigh     = 4'b0100;
    localparam logic [3:0] StWaitLow  = 4'b1000;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
    assign sync   = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            StLow: begin
                if (sync) begin
                    state_d = StWaitHigh;
                    cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!sync) begin
                    state_d = StLow;
                end else if (cnt_q == CntMax) begin
                    state_d = StHigh;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHigh: begin
                if (!sync) begin
                    state_d = StWaitLow;
                    cnt_d   = '0;
                end
            end
            StWaitLow: begin
                if (sync) begin
                    state_d = StHigh;
                end else if (cnt_q == CntMax) begin
                    state_d = StLow;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= StLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed and randomised checks of button_debounce with SYNC_STAGES=2, STABLE_CYCLES=8, CNT_W=4.
module tb_button_debounce;

    localparam int unsigned SyncStages   = 2;
    localparam int unsigned StableCycles = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic level, rise, fall;

    int total = 0;
    int bad   = 0;

    // Run-length model for the random phase: a level is accepted once the
    // synchronised input has shown the same value for StableCycles+1 edges.
    logic mb0, mb1, mlast, ms;
    int   mrun;
    logic exp_level, exp_rise, exp_fall;

    button_debounce #(
        .SYNC_STAGES  (SyncStages),
        .STABLE_CYCLES(StableCycles),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (rst) begin
            mb0 = 0; mb1 = 0; mlast = 0; mrun = 0;
            exp_level = 0; exp_rise = 0; exp_fall = 0;
        end else begin
            ms  = mb1;
            mb1 = mb0;
            mb0 = btn_in;
            exp_rise = 0;
            exp_fall = 0;
            if (ms == mlast) begin
                mrun++;
            end else begin
                mrun  = 1;
                mlast = ms;
            end
            if (mrun >= int'(StableCycles) + 1 && ms != exp_level) begin
                exp_level = ms;
                exp_rise  = ms;
                exp_fall  = !ms;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic l, input logic r, input logic f);
        chk({tag, ".level"}, level, l);
        chk({tag, ".rise"}, rise, r);
        chk({tag, ".fall"}, fall, f);
    endtask

    // Drive v from the next edge (E0); level must flip exactly at E0+10.
    task automatic qualify(input string tag, input logic v);
        btn_in = v;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out({tag, ".wait"}, !v, 1'b0, 1'b0);
        end
        tick();
        chk_out({tag, ".edge"}, v, v, !v);
        tick();
        chk_out({tag, ".after"}, v, 1'b0, 1'b0);
    endtask

    task automatic hold(input string tag, input logic v, input int n, input logic lvl);
        btn_in = v;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_out(tag, lvl, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int   cycles;
        int   len;
        logic v;

        rst    = 1'b1;
        btn_in = 1'b1;

        // Reset dominance with the button held high.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("rst_hold", 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        qualify("rst_release", 1'b1);

        // Clean press and release from a freshly reset LOW state.
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        hold("idle", 1'b0, 12, 1'b0);
        qualify("press", 1'b1);
        hold("press_hold", 1'b1, 28, 1'b1);
        qualify("release", 1'b0);

        // Press bounce: no run reaches the acceptance length.
        hold("bounce_a", 1'b1, 3, 1'b0);
        hold("bounce_b", 1'b0, 2, 1'b0);
        hold("bounce_c", 1'b1, 5, 1'b0);
        hold("bounce_d", 1'b0, 1, 1'b0);
        qualify("bounce_press", 1'b1);

        // Glitches while HIGH of 1, 4 and 7 cycles are all rejected.
        hold("glitch_pre", 1'b1, 20, 1'b1);
        hold("glitch1", 1'b0, 1, 1'b1);
        hold("glitch1_gap", 1'b1, 20, 1'b1);
        hold("glitch4", 1'b0, 4, 1'b1);
        hold("glitch4_gap", 1'b1, 20, 1'b1);
        hold("glitch7", 1'b0, 7, 1'b1);
        hold("glitch7_gap", 1'b1, 20, 1'b1);

        // Nine low cycles are just enough; fall lands at E0+10, then the
        // high input (first sampled at E0+9) requalifies to rise at E0+19.
        hold("low9", 1'b0, 9, 1'b1);
        btn_in = 1'b1;
        tick();
        chk_out("low9.e9", 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("low9.e10", 1'b0, 1'b0, 1'b1);
        for (int i = 11; i < 19; i++) begin
            tick();
            chk_out("low9.requal", 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_out("low9.e19", 1'b1, 1'b1, 1'b0);

        // Reset mid-qualification when cnt==5 (edge E0+7).
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        rst = 1'b0;
        hold("midq_idle", 1'b0, 5, 1'b0);
        hold("midq_qual", 1'b1, 8, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("midq_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        qualify("midq_requal", 1'b1);

        // Random bounce against the run-length model.
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        rst    = 1'b0;
        cycles = 0;
        while (cycles < 2000) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            btn_in = v;
            for (int i = 0; i < len; i++) begin
                tick();
                cycles++;
                chk_out("rand", exp_level, exp_rise, exp_fall);
                chk("rand.excl", rise & fall, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
